// File: rtl/uart_program_loader.sv
// Serial boot loader: an 8N1, 16x-oversampled UART receiver feeding a framed-image
// parser that writes program memory word by word and holds the CPU while loading.
module uart_program_loader #(
  parameter int AB            = 11,
  parameter int DB            = 16,
  parameter int CLKS_PER_TICK = 163
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rx,
  output logic          pm_we,
  output logic [AB-1:0] pm_addr,
  output logic [DB-1:0] pm_wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic          error
);
  localparam int            TW        = $clog2(CLKS_PER_TICK + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);
  localparam logic [31:0]   MAX_WORDS = 32'd1 << AB;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {
    LD_WAIT, LD_CNT_H, LD_CNT_L, LD_DAT_H, LD_DAT_L, LD_CHK, LD_DONE, LD_ERR
  } ld_state_t;

  rx_state_t rx_state, rx_next;
  ld_state_t ld_state, ld_next;

  logic          rx_meta, rx_s, rx_prev;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    os_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // byte_valid / frame_err are single-cycle strobes with no ready: the loader
  // accepts whatever the receiver presents on every cycle, there is no stall.
  logic          byte_valid, frame_err;
  logic [7:0]    rx_byte;

  logic [15:0]   cnt;
  logic [7:0]    chk, hi_byte;
  logic          start_load, latch_cnt_h, latch_cnt_l, latch_hi, do_write;
  logic          go_done, go_err;

  assign tick    = (tick_cnt == TICK_LAST);
  assign rx_byte = shreg;

  always_comb begin
    rx_next    = rx_state;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
      RX_START: if (tick && os_cnt == 4'd7) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && os_cnt == 4'd15 && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (tick && os_cnt == 4'd15) begin
          rx_next    = RX_IDLE;
          byte_valid = rx_s;
          frame_err  = !rx_s;
        end
      end
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Tick counter is held in IDLE so bit sampling is phase-aligned to the start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      tick_cnt <= '0;
      os_cnt   <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      rx_meta  <= rx;
      rx_s     <= rx_meta;
      rx_prev  <= rx_s;
      rx_state <= rx_next;
      if (rx_state == RX_IDLE || tick) tick_cnt <= '0;
      else                             tick_cnt <= tick_cnt + TW'(1);
      if (rx_next != rx_state) os_cnt <= '0;
      else if (tick)           os_cnt <= os_cnt + 4'd1;
      if (rx_state == RX_DATA && tick && os_cnt == 4'd15) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  always_comb begin
    ld_next     = ld_state;
    start_load  = 1'b0;
    latch_cnt_h = 1'b0;
    latch_cnt_l = 1'b0;
    latch_hi    = 1'b0;
    do_write    = 1'b0;
    go_done     = 1'b0;
    go_err      = 1'b0;
    if (frame_err && !(ld_state inside {LD_WAIT, LD_DONE, LD_ERR})) begin
      ld_next = LD_ERR;
      go_err  = 1'b1;
    end else if (byte_valid) begin
      case (ld_state)
        LD_WAIT, LD_DONE, LD_ERR: begin
          if (rx_byte == 8'hA5) begin
            ld_next    = LD_CNT_H;
            start_load = 1'b1;
          end
        end
        LD_CNT_H: begin
          latch_cnt_h = 1'b1;
          ld_next     = LD_CNT_L;
        end
        LD_CNT_L: begin
          latch_cnt_l = 1'b1;
          if ({16'd0, cnt[15:8], rx_byte} > MAX_WORDS) begin
            ld_next = LD_ERR;
            go_err  = 1'b1;
          end else if ({cnt[15:8], rx_byte} == 16'd0) begin
            ld_next = LD_CHK;
          end else begin
            ld_next = LD_DAT_H;
          end
        end
        LD_DAT_H: begin
          latch_hi = 1'b1;
          ld_next  = LD_DAT_L;
        end
        LD_DAT_L: begin
          do_write = 1'b1;
          ld_next  = (cnt == 16'd1) ? LD_CHK : LD_DAT_H;
        end
        LD_CHK: begin
          if (rx_byte == chk) begin
            ld_next = LD_DONE;
            go_done = 1'b1;
          end else begin
            ld_next = LD_ERR;
            go_err  = 1'b1;
          end
        end
        default: ld_next = LD_WAIT;
      endcase
    end
  end

  // Address and count advance on the edge after the write strobe, so pm_addr
  // is stable for the whole pm_we cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_state <= LD_WAIT;
      cnt      <= '0;
      chk      <= '0;
      hi_byte  <= '0;
      pm_we    <= 1'b0;
      pm_addr  <= '0;
      pm_wdata <= '0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      ld_state <= ld_next;
      pm_we    <= do_write;
      if (pm_we) begin
        pm_addr <= pm_addr + AB'(1);
        cnt     <= cnt - 16'd1;
      end
      if (start_load) begin
        pm_addr  <= '0;
        chk      <= '0;
        cnt      <= '0;
        done     <= 1'b0;
        error    <= 1'b0;
        cpu_hold <= 1'b1;
      end
      if (latch_cnt_h) cnt[15:8] <= rx_byte;
      if (latch_cnt_l) cnt[7:0]  <= rx_byte;
      if (latch_hi)    hi_byte   <= rx_byte;
      if (latch_hi || do_write) chk <= chk ^ rx_byte;
      if (do_write)    pm_wdata  <= DB'({hi_byte, rx_byte});
      if (go_done) begin
        done     <= 1'b1;
        cpu_hold <= 1'b0;
      end
      if (go_err) error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader: drives UART frames and checks memory writes and
// status against a frame-level model (small AB keeps the full-image load short).
module tb_uart_program_loader;
  localparam int AB  = 3;
  localparam int DB  = 16;
  localparam int CPT = 4;
  localparam int BIT = 16 * CPT;
  localparam int AW  = AB + DB;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx = 1'b1;
  logic          pm_we, cpu_hold, done, error;
  logic [AB-1:0] pm_addr;
  logic [DB-1:0] pm_wdata;

  uart_program_loader #(.AB(AB), .DB(DB), .CLKS_PER_TICK(CPT)) dut (
    .clk(clk), .reset(reset), .rx(rx), .pm_we(pm_we), .pm_addr(pm_addr),
    .pm_wdata(pm_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] obs[$];
  int            n_checks = 0;
  int            n_pass   = 0;
  logic          m_done, m_err, m_hold;
  logic [AB-1:0] m_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Scoreboard: every write strobe must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (reset && pm_we) begin
      obs.push_back({pm_addr, pm_wdata});
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr %0d data 0x%0h, want no write", pm_addr, pm_wdata);
      end else begin
        logic [AW-1:0] e;
        e = exp_q.pop_front();
        if (e === {pm_addr, pm_wdata}) n_pass++;
        else $display("FAIL write: got addr %0d data 0x%0h, want addr %0d data 0x%0h",
                      pm_addr, pm_wdata, e[AW-1:DB], e[DB-1:0]);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic check_status(input string name);
    check({name, "_done"}, done, m_done);
    check({name, "_error"}, error, m_err);
    check({name, "_hold"}, cpu_hold, m_hold);
    check({name, "_addr"}, pm_addr, m_addr);
    check({name, "_pending"}, exp_q.size(), 0);
  endtask

  // Frame-level model: derive writes and final status from the frame bytes.
  task automatic run_frame(input string name, input logic [7:0] fb[$]);
    int         n;
    logic [7:0] x;
    n = {fb[1], fb[2]};
    x = 8'h00;
    if (n > (1 << AB)) begin
      m_err = 1'b1; m_done = 1'b0; m_hold = 1'b1; m_addr = '0;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({AB'(i), fb[3+2*i], fb[4+2*i]});
        x = x ^ fb[3+2*i] ^ fb[4+2*i];
      end
      m_done = (fb[3+2*n] == x);
      m_err  = !m_done;
      m_hold = m_err;
      m_addr = AB'(n);
    end
    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i], 1'b1);
      if (i == 0) begin
        check({name, "_hold_loading"}, cpu_hold, 1);
        check({name, "_done_cleared"}, done, 0);
        check({name, "_error_cleared"}, error, 0);
      end
    end
    repeat (4) @(negedge clk);
    check_status(name);
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] x;
    int         n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_we", pm_we, 0);
    check("rst_addr", pm_addr, 0);
    check("rst_wdata", pm_wdata, 0);
    check("rst_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Good load
    f = {8'hA5, 8'h00, 8'h02, 8'h08, 8'h01, 8'h10, 8'h02, 8'h1B};
    obs.delete();
    run_frame("good", f);
    check("good_nwrites", obs.size(), 2);
    check("good_w0", obs[0], {3'd0, 16'h0801});
    check("good_w1", obs[1], {3'd1, 16'h1002});
    check("good_done_lit", done, 1);

    // Idle glitch and ignored bytes leave the DONE state untouched
    obs.delete();
    rx = 1'b0;
    repeat (CPT) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (4) @(negedge clk);
    check_status("ignore");
    check("ignore_nwrites", obs.size(), 0);

    // Bad checksum, then resend
    f[7] = 8'h1C;
    obs.delete();
    run_frame("badchk", f);
    check("badchk_nwrites", obs.size(), 2);
    check("badchk_error_lit", error, 1);
    check("badchk_hold_lit", cpu_hold, 1);
    f[7] = 8'h1B;
    run_frame("resend", f);

    // Empty image
    f = {8'hA5, 8'h00, 8'h00, 8'h00};
    run_frame("empty", f);
    check("empty_done_lit", done, 1);

    // Stop bit 0 while expecting a high data byte
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    m_done = 1'b0; m_err = 1'b1; m_hold = 1'b1; m_addr = '0;
    check_status("stoperr");

    // Oversize counts: 0x0801 and one past capacity
    f = {8'hA5, 8'h08, 8'h01};
    run_frame("over", f);
    check("over_error_lit", error, 1);
    f = {8'hA5, 8'h00, 8'h09};
    run_frame("over9", f);

    // Reset between the high and low byte of word 1
    exp_q.push_back({3'd0, 16'h0801});
    f = {8'hA5, 8'h00, 8'h02, 8'h08, 8'h01, 8'h10};
    for (int i = 0; i < f.size(); i++) send_byte(f[i], 1'b1);
    repeat (5) @(negedge clk);
    check("midload_hold", cpu_hold, 1);
    #2 reset = 1'b0;
    #1;
    check("arst_we", pm_we, 0);
    check("arst_addr", pm_addr, 0);
    check("arst_wdata", pm_wdata, 0);
    check("arst_hold", cpu_hold, 0);
    check("arst_done", done, 0);
    check("arst_error", error, 0);
    check("arst_pending", exp_q.size(), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    f = {8'hA5, 8'h00, 8'h02, 8'h08, 8'h01, 8'h10, 8'h02, 8'h1B};
    run_frame("after_rst", f);

    // Full image: 2^AB words, data = address; XOR of 0..7 is 0
    f = {8'hA5, 8'h00, 8'(1 << AB)};
    for (int i = 0; i < (1 << AB); i++) begin
      f.push_back(8'h00);
      f.push_back(8'(i));
    end
    f.push_back(8'h00);
    obs.delete();
    run_frame("full", f);
    check("full_nwrites", obs.size(), 8);
    check("full_last", obs[7], {3'd7, 16'h0007});
    check("full_wrap", pm_addr, 0);

    // Random frames with good or corrupted checksums
    for (int k = 0; k < 2; k++) begin
      n = $urandom_range(1, 2);
      f = {8'hA5, 8'h00, 8'(n)};
      x = 8'h00;
      for (int i = 0; i < 2 * n; i++) begin
        f.push_back(8'($urandom_range(0, 255)));
        x = x ^ f[3+i];
      end
      if ($urandom_range(0, 1) == 1) x = x ^ 8'($urandom_range(1, 255));
      f.push_back(x);
      run_frame("rand", f);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
